// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder.
// Bus widths and the default base come from my_cpu.vh.
`include "my_cpu.vh"

package sram_responder_pkg;

    localparam int          DATA_W            = `MY_CPU_DATA_W;
    localparam int          STRB_W            = `MY_CPU_STRB_W;
    localparam int          BUS_ADDR_W        = `MY_CPU_ADDR_W;
    localparam logic [31:0] SRAM_BASE_DEFAULT = `MY_CPU_SRAM_BASE;

    // Replace the byte lanes of old_word that are enabled in lane_we.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] lane_we
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (lane_we[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/my_cpu.vh
// Shared CPU bus macros: data/strobe/address widths and the default SRAM window base.
`ifndef MY_CPU_VH
`define MY_CPU_VH

`define MY_CPU_DATA_W    32
`define MY_CPU_STRB_W    4
`define MY_CPU_ADDR_W    32
`define MY_CPU_SRAM_BASE 32'h1C00_0000

`endif

// File: rtl/sram_byte_lane.sv
// One byte lane of the SRAM: 2^ADDR_W x 8, single write enable, registered read.
// The read is read-first: rdata shows the byte held before a same-cycle write.
module sram_byte_lane #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    // Storage write and registered read; rdata only moves on an enabled access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM responder: decodes a byte-addressed window at BASE, range-checks,
// counts accepted reads/writes and returns data one cycle after each access.
// Optional feature: define SRAM_WR_FWD_EN for write-first data on writes;
// otherwise a write returns the word held before the write (read-first).
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] BASE   = SRAM_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sram_en,
    input  logic [STRB_W-1:0]     sram_we,
    input  logic [BUS_ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W-1:0]     sram_rdata,
    output logic                  sram_err,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);

    // Byte offset bits [1:0] never matter, so the decode works on word offsets.
    logic [29:0]       word_off;
    logic              in_range;
    logic              is_wr;
    logic              acc_ok;
    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] lane_rdata;
    logic              zero_q;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^sram_addr[1:0];
    assign word_off = sram_addr[31:2] - BASE[31:2];
    assign in_range = word_off < (30'(1) << ADDR_W);
    assign word_idx = word_off[ADDR_W-1:0];
    assign is_wr    = |sram_we;
    // Accesses presented during reset are dropped entirely.
    assign acc_ok   = sram_en & ~reset & in_range;

    for (genvar i = 0; i < STRB_W; i++) begin : g_lane
        sram_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .en    (acc_ok),
            .we    (acc_ok & sram_we[i]),
            .addr  (word_idx),
            .wdata (sram_wdata[8*i +: 8]),
            .rdata (lane_rdata[8*i +: 8])
        );
    end

    // Response control, sticky error and the accepted-access counters.
    // zero_q forces the response to 0 after reset or an out-of-range access and
    // is held across idle cycles, as are the lane read registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q   <= 1'b1;
            sram_err <= 1'b0;
            rd_cnt   <= 32'd0;
            wr_cnt   <= 32'd0;
        end else if (sram_en) begin
            if (in_range) begin
                zero_q <= 1'b0;
                if (is_wr) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end else begin
                zero_q   <= 1'b1;
                sram_err <= 1'b1;
            end
        end
    end

`ifdef SRAM_WR_FWD_EN
    logic [STRB_W-1:0] fwd_we_q;
    logic [DATA_W-1:0] fwd_data_q;

    // Capture the write lanes of the last accepted access for write-first return.
    always_ff @(posedge clk) begin
        if (acc_ok) begin
            fwd_we_q   <= sram_we;
            fwd_data_q <= sram_wdata;
        end
    end

    assign sram_rdata = zero_q ? '0 : merge_lanes(lane_rdata, fwd_data_q, fwd_we_q);
`else
    assign sram_rdata = zero_q ? '0 : lane_rdata;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed scenarios followed by randomized traffic,
// checked against a word-level reference model of the SRAM window.
module tb_sram_responder;

  localparam int          ADDR_W = 14;
  localparam logic [31:0] BASE   = 32'h1C00_0000;
  localparam logic [31:0] SPAN   = 32'h4 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [int];
  logic [31:0] exp_rdata;
  logic [31:0] exp_err;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;
  bit          rdata_known;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_err   (sram_err),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Word-level model of one clock edge.
  task automatic model(input bit rst, input bit en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    logic [31:0] old_w;
    logic [31:0] new_w;
    bit          known;
    int          idx;
    if (rst) begin
      exp_rdata = 0; exp_err = 0; exp_rd = 0; exp_wr = 0; rdata_known = 1;
    end else if (en) begin
      off = addr - BASE;
      if (off < SPAN) begin
        idx   = int'(off >> 2);
        known = m_mem.exists(idx);
        old_w = known ? m_mem[idx] : 32'h0;
        if (we == 4'h0) begin
          exp_rd      = exp_rd + 1;
          exp_rdata   = old_w;
          rdata_known = known;
        end else begin
          new_w = old_w;
          for (int i = 0; i < 4; i++)
            if (we[i]) new_w[8*i +: 8] = wdata[8*i +: 8];
          exp_wr = exp_wr + 1;
`ifdef SRAM_WR_FWD_EN
          exp_rdata   = new_w;
          rdata_known = known || (we == 4'hF);
`else
          exp_rdata   = old_w;
          rdata_known = known;
`endif
          if (known || we == 4'hF) m_mem[idx] = new_w;
        end
      end else begin
        exp_rdata = 0; exp_err = 1; rdata_known = 1;
      end
    end
  endtask

  task automatic compare_all();
    if (rdata_known) check("rdata", sram_rdata, exp_rdata);
    check("err", {31'd0, sram_err}, exp_err);
    check("rd_cnt", rd_cnt, exp_rd);
    check("wr_cnt", wr_cnt, exp_wr);
  endtask

  // Driver: called at a negedge, applies one cycle and checks the response.
  task automatic step(input bit rst, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    reset = rst; sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata;
    @(posedge clk);
    model(rst, en, we, addr, wdata);
    @(negedge clk);
    reset = 1'b0; sram_en = 1'b0; sram_we = 4'h0;
    compare_all();
  endtask

  initial begin
    logic [31:0] exp32;
    logic [31:0] rd_before;
    logic [31:0] held;
    logic [31:0] a;
    logic [3:0]  w;
    int          r;

    reset = 1'b1; sram_en = 1'b0; sram_we = 4'h0; sram_addr = '0; sram_wdata = '0;
    @(negedge clk);
    step(1, 0, 4'h0, 32'h0, 32'h0);
    step(1, 0, 4'h0, 32'h0, 32'h0);
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_cnt", rd_cnt | wr_cnt, 32'h0);

    // Full write then read of the same word.
    step(0, 1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
    step(0, 1, 4'h0, BASE + 32'h10, 32'h0);
    check("req030_rdata", sram_rdata, 32'hDEAD_BEEF);
    check("req030_wr", wr_cnt, 32'd1);
    check("req030_rd", rd_cnt, 32'd1);

    // Partial lane write merges with the preloaded word.
    step(0, 1, 4'hF, BASE + 32'h20, 32'h1122_3344);
    step(0, 1, 4'b0101, BASE + 32'h20, 32'hAABB_CCDD);
    step(0, 1, 4'h0, BASE + 32'h20, 32'h0);
    check("req031_merge", sram_rdata, 32'h11BB_33DD);

    // Data returned by a write.
    step(0, 1, 4'hF, BASE, 32'h0000_0001);
    step(0, 1, 4'hF, BASE, 32'h0000_0002);
`ifdef SRAM_WR_FWD_EN
    exp32 = 32'h0000_0002;
`else
    exp32 = 32'h0000_0001;
`endif
    check("req032_wr_data", sram_rdata, exp32);

    // Out-of-range read: zero data, sticky error, no count, array intact.
    rd_before = exp_rd;
    step(0, 1, 4'h0, BASE + SPAN, 32'h0);
    check("req033_rdata", sram_rdata, 32'h0);
    check("req033_err", {31'd0, sram_err}, 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 4'h0, 32'h0, 32'h0);
    check("req033_err_held", {31'd0, sram_err}, 32'd1);
    check("req033_rd_cnt", rd_cnt, rd_before);
    step(0, 1, 4'h0, BASE + 32'h10, 32'h0);
    check("req033_array", sram_rdata, 32'hDEAD_BEEF);

    // Reset with a read presented in the reset cycle.
    step(0, 1, 4'hF, BASE + 32'h40, 32'h5A5A_5A5A);
    step(1, 1, 4'h0, BASE + 32'h40, 32'h0);
    check("req034_rdata", sram_rdata, 32'h0);
    check("req034_cnt", rd_cnt | wr_cnt, 32'h0);
    check("req034_err", {31'd0, sram_err}, 32'd0);
    step(0, 1, 4'h0, BASE + 32'h40, 32'h0);
    check("req034_keep", sram_rdata, 32'h5A5A_5A5A);

    // Write counter wrap.
    force dut.wr_cnt = 32'hFFFF_FFFE;
    exp_wr = 32'hFFFF_FFFE;
    step(0, 0, 4'h0, 32'h0, 32'h0);
    release dut.wr_cnt;
    step(0, 1, 4'hF, BASE + 32'h44, 32'h0101_0101);
    check("req035_wr0", wr_cnt, 32'hFFFF_FFFF);
    held = sram_rdata;
    step(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 4'h0, 32'h0, 32'h0);
    check("req035_hold", sram_rdata, held);
    step(0, 1, 4'hF, BASE + 32'h48, 32'h0202_0202);
    check("req035_wr1", wr_cnt, 32'h0000_0000);
    step(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 1, 4'hF, BASE + 32'h4C, 32'h0303_0303);
    check("req035_wr2", wr_cnt, 32'h0000_0001);

    // Randomized traffic over a preloaded block of words.
    for (int k = 0; k < 32; k++)
      step(0, 1, 4'hF, BASE + ((200 + k) << 2), $urandom);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)
        a = BASE - 32'h4;
      else if (r < 7)
        a = BASE + SPAN + ($urandom_range(0, 255) << 2);
      else
        a = BASE + ((200 + $urandom_range(0, 31)) << 2) + $urandom_range(0, 3);
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, w, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
